// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mie/mip, mtime/mtimecmp and the irq request/ack handshake.
// Optional mtime prescaler enabled by defining MTIME_PRESCALE_EN (divides ticks by TIMER_DIV).
module irq_ctrl #(
    parameter int unsigned TIMER_DIV   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic [11:0] mem1_csr_addr,
    input  logic [1:0]  mem1_csr_write,
    input  logic [31:0] mem1_csr_din,
    output logic        irq_csr_hit,
    output logic [31:0] irq_csr_dout,
    input  logic        mstatus_mie,
    input  logic        ext_irq,
    output logic        irq_req,
    output logic [4:0]  irq_cause,
    input  logic        irq_ack,
    output logic        irq_mtip
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("irq_ctrl: SYNC_STAGES must be at least 2");
    end
    if (TIMER_DIV < 1 || TIMER_DIV > 65535) begin : g_bad_div
        $error("irq_ctrl: TIMER_DIV must be in 1..65535");
    end

    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_MTIME_L = 12'h7C0;
    localparam logic [11:0] A_MTIME_H = 12'h7C1;
    localparam logic [11:0] A_MCMP_L  = 12'h7C2;
    localparam logic [11:0] A_MCMP_H  = 12'h7C3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                 state_q, state_d;
    logic                   wait_q, wait_d;
    logic [2:0]             mie_q;          // {MEIE, MTIE, MSIE}
    logic                   msip_q;
    logic [63:0]            mtime_q, mtimecmp_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   meip;
    logic [2:0]             pend;           // {MEI, MSI, MTI}: priority order, high to low
    logic [4:0]             best_cause;
    logic [31:0]            wdata;
    logic                   csr_we, wr_mie, wr_mip, wr_mt_l, wr_mt_h, wr_cmp_l, wr_cmp_h;
    logic                   mtime_tick;

    assign meip = sync_q[SYNC_STAGES-1];
    assign pend = {meip & mie_q[2], msip_q & mie_q[0], irq_mtip & mie_q[1]};
    assign best_cause = pend[2] ? 5'd11 : (pend[1] ? 5'd3 : 5'd7);

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        irq_csr_hit  = 1'b1;
        irq_csr_dout = '0;
        case (mem1_csr_addr)
            A_MIE:     irq_csr_dout = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
            A_MIP:     irq_csr_dout = {20'd0, meip, 3'd0, irq_mtip, 3'd0, msip_q, 3'd0};
            A_MTIME_L: irq_csr_dout = mtime_q[31:0];
            A_MTIME_H: irq_csr_dout = mtime_q[63:32];
            A_MCMP_L:  irq_csr_dout = mtimecmp_q[31:0];
            A_MCMP_H:  irq_csr_dout = mtimecmp_q[63:32];
            default:   irq_csr_hit  = 1'b0;
        endcase
    end

    always_comb begin
        case (mem1_csr_write)
            2'b01:   wdata = mem1_csr_din;
            2'b10:   wdata = irq_csr_dout | mem1_csr_din;
            2'b11:   wdata = irq_csr_dout & ~mem1_csr_din;
            default: wdata = irq_csr_dout;
        endcase
    end

    assign csr_we   = irq_csr_hit && (mem1_csr_write != 2'b00);
    assign wr_mie   = csr_we && (mem1_csr_addr == A_MIE);
    assign wr_mip   = csr_we && (mem1_csr_addr == A_MIP);
    assign wr_mt_l  = csr_we && (mem1_csr_addr == A_MTIME_L);
    assign wr_mt_h  = csr_we && (mem1_csr_addr == A_MTIME_H);
    assign wr_cmp_l = csr_we && (mem1_csr_addr == A_MCMP_L);
    assign wr_cmp_h = csr_we && (mem1_csr_addr == A_MCMP_H);

`ifdef MTIME_PRESCALE_EN
    localparam logic [15:0] DIV_LAST = 16'(TIMER_DIV - 1);
    logic [15:0] presc_q;

    assign mtime_tick = (presc_q == DIV_LAST);

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if (wr_mt_l || wr_mt_h || mtime_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end
`else
    assign mtime_tick = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            mie_q      <= '0;
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_mtip   <= 1'b0;
            sync_q     <= '0;
        end else begin
            if (wr_mie)   mie_q  <= {wdata[11], wdata[7], wdata[3]};
            if (wr_mip)   msip_q <= wdata[3];
            if (wr_cmp_l) mtimecmp_q[31:0]  <= wdata;
            if (wr_cmp_h) mtimecmp_q[63:32] <= wdata;
            // A software write to either half suppresses that cycle's increment.
            if (wr_mt_l || wr_mt_h) begin
                if (wr_mt_l) mtime_q[31:0]  <= wdata;
                if (wr_mt_h) mtime_q[63:32] <= wdata;
            end else if (mtime_tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
            irq_mtip <= (mtime_q >= mtimecmp_q);
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_irq};
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = 1'b0;
        case (state_q)
            IDLE: if ((pend != 3'b000) && mstatus_mie) state_d = REQ;
            REQ: begin
                if (irq_ack)                                   state_d = WAIT;
                else if ((pend == 3'b000) || !mstatus_mie)     state_d = IDLE;
            end
            WAIT: begin
                // Hold off re-requesting until MIE is seen low, two cycles at most.
                if (!mstatus_mie || wait_q) state_d = IDLE;
                else                        wait_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wait_q    <= 1'b0;
            irq_req   <= 1'b0;
            irq_cause <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            irq_req <= (state_d == REQ);
            if ((state_q == IDLE) && (pend != 3'b000)) irq_cause <= best_cause;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: CSR access table plus timer/priority/handshake sequences.
module tb_irq_ctrl;

    logic        clk_core;
    logic        reset_n;
    logic [11:0] mem1_csr_addr;
    logic [1:0]  mem1_csr_write;
    logic [31:0] mem1_csr_din;
    logic        irq_csr_hit;
    logic [31:0] irq_csr_dout;
    logic        mstatus_mie;
    logic        ext_irq;
    logic        irq_req;
    logic [4:0]  irq_cause;
    logic        irq_ack;
    logic        irq_mtip;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.TIMER_DIV(1), .SYNC_STAGES(2)) u_dut (
        .clk_core       (clk_core),
        .reset_n        (reset_n),
        .mem1_csr_addr  (mem1_csr_addr),
        .mem1_csr_write (mem1_csr_write),
        .mem1_csr_din   (mem1_csr_din),
        .irq_csr_hit    (irq_csr_hit),
        .irq_csr_dout   (irq_csr_dout),
        .mstatus_mie    (mstatus_mie),
        .ext_irq        (ext_irq),
        .irq_req        (irq_req),
        .irq_cause      (irq_cause),
        .irq_ack        (irq_ack),
        .irq_mtip       (irq_mtip)
    );

`ifdef MTIME_PRESCALE_EN
    logic [1:0]  p_write;
    logic [31:0] p_din;
    logic        p_hit, p_req, p_mtip;
    logic [31:0] p_dout;
    logic [4:0]  p_cause;

    irq_ctrl #(.TIMER_DIV(4), .SYNC_STAGES(2)) u_presc (
        .clk_core       (clk_core),
        .reset_n        (reset_n),
        .mem1_csr_addr  (12'h7C0),
        .mem1_csr_write (p_write),
        .mem1_csr_din   (p_din),
        .irq_csr_hit    (p_hit),
        .irq_csr_dout   (p_dout),
        .mstatus_mie    (1'b0),
        .ext_irq        (1'b0),
        .irq_req        (p_req),
        .irq_cause      (p_cause),
        .irq_ack        (1'b0),
        .irq_mtip       (p_mtip)
    );
`endif

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] din;
        logic        exp_hit;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t rd_vecs[6];
    vec_t wr_vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] din);
        mem1_csr_addr  = addr;
        mem1_csr_write = op;
        mem1_csr_din   = din;
        tick();
        mem1_csr_write = 2'b00;
    endtask

    task automatic csr_rd(input logic [11:0] addr, output logic [31:0] data);
        mem1_csr_addr = addr;
        #1;
        data = irq_csr_dout;
    endtask

    initial begin
        logic [31:0] rd, rd_hi;
        logic        found;
        logic        ack_exp[4];

        rd_vecs[0] = '{12'h7C2, 2'b00, 32'h0, 1'b1, 32'hFFFF_FFFF};
        rd_vecs[1] = '{12'h7C3, 2'b00, 32'h0, 1'b1, 32'hFFFF_FFFF};
        rd_vecs[2] = '{12'h304, 2'b00, 32'h0, 1'b1, 32'h0};
        rd_vecs[3] = '{12'h344, 2'b00, 32'h0, 1'b1, 32'h0};
        rd_vecs[4] = '{12'h300, 2'b00, 32'h0, 1'b0, 32'h0};
        rd_vecs[5] = '{12'h7C4, 2'b00, 32'h0, 1'b0, 32'h0};

        wr_vecs[0]  = '{12'h304, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h888};
        wr_vecs[1]  = '{12'h304, 2'b11, 32'h0000_0008, 1'b1, 32'h880};
        wr_vecs[2]  = '{12'h304, 2'b10, 32'h0000_0008, 1'b1, 32'h888};
        wr_vecs[3]  = '{12'h304, 2'b01, 32'h0000_0080, 1'b1, 32'h080};
        wr_vecs[4]  = '{12'h304, 2'b11, 32'hFFFF_FFFF, 1'b1, 32'h000};
        wr_vecs[5]  = '{12'h304, 2'b10, 32'h0000_0800, 1'b1, 32'h800};
        wr_vecs[6]  = '{12'h304, 2'b00, 32'hFFFF_FFFF, 1'b1, 32'h800};
        wr_vecs[7]  = '{12'h344, 2'b10, 32'hFFFF_FFFF, 1'b1, 32'h008};
        wr_vecs[8]  = '{12'h344, 2'b11, 32'h0000_0008, 1'b1, 32'h000};
        wr_vecs[9]  = '{12'h344, 2'b01, 32'h0000_0888, 1'b1, 32'h008};
        wr_vecs[10] = '{12'h344, 2'b01, 32'h0000_0000, 1'b1, 32'h000};

        reset_n        = 1'b0;
        mem1_csr_addr  = '0;
        mem1_csr_write = 2'b00;
        mem1_csr_din   = '0;
        mstatus_mie    = 1'b0;
        ext_irq        = 1'b0;
        irq_ack        = 1'b0;
`ifdef MTIME_PRESCALE_EN
        p_write = 2'b00;
        p_din   = '0;
`endif
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        check("reset_irq_req", irq_req, 1'b0);
        check("reset_irq_mtip", irq_mtip, 1'b0);
        check("reset_irq_cause", irq_cause, 5'd0);
        for (int i = 0; i < 6; i++) begin
            mem1_csr_addr = rd_vecs[i].addr;
            #1;
            check($sformatf("rd_hit_%0d", i), irq_csr_hit, rd_vecs[i].exp_hit);
            check($sformatf("rd_dout_%0d", i), irq_csr_dout, rd_vecs[i].exp_dout);
        end

        // Write-op semantics on mie/mip, FSM kept quiet with mstatus_mie=0.
        for (int i = 0; i < 11; i++) begin
            csr_wr(wr_vecs[i].addr, wr_vecs[i].op, wr_vecs[i].din);
            check($sformatf("wr_dout_%0d", i), irq_csr_dout, wr_vecs[i].exp_dout);
        end

        // Timer interrupt: mtimecmp=20, mtime restarted at 0.
        csr_wr(12'h7C2, 2'b01, 32'd20);
        csr_wr(12'h7C0, 2'b01, 32'd0);
        csr_wr(12'h7C3, 2'b01, 32'd0);
        csr_wr(12'h304, 2'b01, 32'h80);
        mstatus_mie = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (irq_mtip) found = 1'b1;
            else          tick();
        end
        check("mtip_rise_seen", found, 1'b1);
        csr_rd(12'h7C0, rd);
        check("mtime_at_mtip_rise", rd, 32'd21);
        check("req_lags_mtip", irq_req, 1'b0);
        tick();
        check("timer_req", irq_req, 1'b1);
        check("timer_cause", irq_cause, 5'd7);
        irq_ack = 1'b1;
        ack_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick();
            irq_ack = 1'b0;
            check($sformatf("wait_req_%0d", i), irq_req, ack_exp[i]);
        end
        csr_wr(12'h304, 2'b01, 32'h0);
        check("mie_clear_prewrite_req", irq_req, 1'b1);
        tick();
        check("mie_clear_withdraw", irq_req, 1'b0);
        mstatus_mie = 1'b0;

        // mtime carry from low to high half, then full 64-bit wrap.
        csr_wr(12'h7C1, 2'b01, 32'h0);
        csr_wr(12'h7C0, 2'b01, 32'hFFFF_FFFF);
        tick();
        csr_rd(12'h7C0, rd);
        csr_rd(12'h7C1, rd_hi);
        check("carry_low", rd, 32'h0);
        check("carry_high", rd_hi, 32'h1);
        csr_wr(12'h7C1, 2'b01, 32'hFFFF_FFFF);
        csr_wr(12'h7C0, 2'b01, 32'hFFFF_FFFF);
        tick();
        csr_rd(12'h7C0, rd);
        csr_rd(12'h7C1, rd_hi);
        check("wrap_low", rd, 32'h0);
        check("wrap_high", rd_hi, 32'h0);
        check("wrap_mtip_lag", irq_mtip, 1'b1);
        tick();
        check("wrap_mtip_clear", irq_mtip, 1'b0);

        // All three sources at once: MEI wins, then MSI after ext_irq drops.
        ext_irq = 1'b1;
        csr_wr(12'h304, 2'b01, 32'h888);
        csr_wr(12'h344, 2'b10, 32'h8);
        csr_wr(12'h7C2, 2'b01, 32'h0);
        tick();
        tick();
        csr_rd(12'h344, rd);
        check("mip_all_pending", rd, 32'h888);
        mstatus_mie = 1'b1;
        tick();
        check("mei_req", irq_req, 1'b1);
        check("mei_cause", irq_cause, 5'd11);
        ext_irq = 1'b0;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("mei_ack_req", irq_req, 1'b0);
        repeat (3) tick();
        check("msi_req", irq_req, 1'b1);
        check("msi_cause", irq_cause, 5'd3);
        ext_irq = 1'b1;
        repeat (3) tick();
        check("cause_held_in_req", irq_cause, 5'd3);
        check("req_held", irq_req, 1'b1);
        ext_irq = 1'b0;

        // Clearing MSIP before ack withdraws the request.
        csr_wr(12'h304, 2'b01, 32'h008);
        csr_wr(12'h344, 2'b11, 32'h8);
        check("msip_clear_prewrite_req", irq_req, 1'b1);
        tick();
        check("msip_clear_withdraw", irq_req, 1'b0);

`ifdef MTIME_PRESCALE_EN
        p_din   = 32'd5;
        p_write = 2'b01;
        tick();
        p_write = 2'b00;
        check("presc_written", p_dout, 32'd5);
        repeat (3) tick();
        check("presc_hold3", p_dout, 32'd5);
        tick();
        check("presc_tick1", p_dout, 32'd6);
        repeat (4) tick();
        check("presc_tick2", p_dout, 32'd7);
`endif

        // 1-cycle request latency, then asynchronous reset mid-REQ.
        csr_wr(12'h344, 2'b10, 32'h8);
        check("msip_set_prewrite_req", irq_req, 1'b0);
        tick();
        check("msip_req", irq_req, 1'b1);
        check("msip_req_cause", irq_cause, 5'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_req", irq_req, 1'b0);
        check("async_reset_cause", irq_cause, 5'd0);
        check("async_reset_mtip", irq_mtip, 1'b0);
        csr_rd(12'h7C2, rd);
        check("async_reset_mtimecmp", rd, 32'hFFFF_FFFF);
        csr_rd(12'h304, rd);
        check("async_reset_mie", rd, 32'h0);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Machine-mode interrupt controller beside the CSR unit. Owns mie, mip, a 64-bit machine timer (mtime) and its compare register (mtimecmp). Prioritises pending, enabled interrupts and runs a request/acknowledge handshake with the CSR unit, which injects the trap at the writeback boundary. CSR reads and writes arrive on the same memory1 access port that the CSR unit decodes.

Parameters:
TIMER_DIV, 1, core clocks per mtime tick; legal range 1..65535; used only when MTIME_PRESCALE_EN is defined.
SYNC_STAGES, 2, flop stages on the asynchronous ext_irq input; minimum 2.

Ports:
clk_core  in  1  core clock
reset_n  in  1  asynchronous active-low reset
mem1_csr_addr  in  12  CSR address
mem1_csr_write  in  2  write op: 00 none, 01 write, 10 set, 11 clear
mem1_csr_din  in  32  CSR write operand
irq_csr_hit  out  1  address is owned by this block (combinational)
irq_csr_dout  out  32  read data; 0 when irq_csr_hit=0
mstatus_mie  in  1  global interrupt enable (mstatus.MIE)
ext_irq  in  1  level-sensitive external interrupt, asynchronous to clk_core
irq_req  out  1  interrupt request to CSR unit
irq_cause  out  5  cause code, valid while irq_req=1
irq_ack  in  1  CSR unit has taken the interrupt this cycle
irq_mtip  out  1  timer pending, for debug

Behaviour:
- Reset is asynchronous on negedge reset_n. Reset values:
  - mie = 0, msip = 0, mtime = 0, mtimecmp = all ones
  - synchroniser flops = 0
  - FSM = IDLE
  - irq_req = 0, irq_cause = 0, irq_mtip = 0
- Owned addresses, any other address gives irq_csr_hit=0:
  - 0x304 mie: bits 3, 7 and 11 writable; all other bits read 0.
  - 0x344 mip: bit 3 (MSIP) writable; bit 7 = MTIP and bit 11 = MEIP are read-only; writes to them are ignored.
  - 0x7C0 mtime[31:0], 0x7C1 mtime[63:32]
  - 0x7C2 mtimecmp[31:0], 0x7C3 mtimecmp[63:32]
- Write data: for op 01 it is din; for op 10 it is dout | din; for op 11 it is dout & ~din. The write commits on the next clock edge.
- mtime:
  - Increments by 1 each tick and wraps from 2^64-1 to 0.
  - In a cycle where either half of mtime is written, the written value wins and there is no increment.
  - The non-written half holds.
- MTIP is registered: irq_mtip <= (mtime >= mtimecmp), unsigned 64-bit, compared on current register values. It lags a timer or compare update by 1 cycle.
- MEIP is ext_irq after SYNC_STAGES flops. It is level-sensitive with no latch, so it clears when ext_irq drops.
- pend = {MEIP,MTIP,MSIP} & mie[11,7,3]. Priority is MEI (cause 11) > MSI (cause 3) > MTI (cause 7).
- FSM:
  - IDLE:
    - If pend != 0 and mstatus_mie=1, go to REQ.
    - Capture the highest-priority cause into irq_cause.
  - REQ:
    - irq_req=1; irq_cause is held stable.
    - If irq_ack=1, go to WAIT.
    - Else if pend drops to 0 or mstatus_mie=0, go to IDLE with irq_req=0 (request withdrawn, no trap).
    - A higher-priority source arriving while in REQ does not change irq_cause. It is served on the next entry.
  - WAIT:
    - irq_req=0.
    - Stay until mstatus_mie=0 is observed, or for at most 2 cycles, then go to IDLE. This prevents a double request before MIE clears.
  - irq_ack while not in REQ is ignored.
- irq_req is registered, giving 1-cycle latency from a pend/mstatus_mie condition to irq_req=1.
- Simultaneous CSR write to mie/mip and state evaluation: the FSM uses pre-write values. The new value takes effect the following cycle.
- Reset asserted mid-REQ drops irq_req immediately (asynchronous).

Optional Feature:
MTIME_PRESCALE_EN:
- Defined:
  - A 16-bit prescale counter counts 0..TIMER_DIV-1.
  - mtime ticks when the counter wraps to 0.
  - A write to mtime also clears the prescaler.
- Undefined: there is no prescaler and mtime ticks every clk_core cycle. TIMER_DIV is ignored.

Test Plan:
- Reset: read 0x7C2/0x7C3 -> 0xFFFFFFFF; read 0x304 -> 0; irq_req=0; irq_mtip=0.
- Write mtimecmp={0,20}, mtime=0, mie=0x80, mstatus_mie=1 -> irq_mtip rises when mtime=20; irq_req=1 one cycle later with irq_cause=7; irq_ack pulse -> WAIT -> IDLE.
- mtime low = 0xFFFFFFFF, high = 0 -> after 1 tick reads give low=0, high=1. Write high=0xFFFFFFFF with low=0xFFFFFFFF -> wraps to 0 and MTIP then follows the compare.
- mie=0x888, ext_irq=1, mip set bit3, MTIP=1 together -> irq_cause=11. Drop ext_irq and ack -> next request has irq_cause=3.
- irq_req=1 (cause 3), then clear mip bit3 via op 11 with din=0x8 before ack -> irq_req=0 two cycles later, no ack required.
- With MTIME_PRESCALE_EN and TIMER_DIV=4: mtime increments every 4 cycles. A write to mtime restarts the 4-cycle count.
